// File: rtl/hc4511_scan_if.sv
// Signal bundle between the scan driver and its host/decoder side.
// Host drives the value and mode controls; the driver returns the HC4511 pins.
interface hc4511_scan_if;
    logic [15:0] data;
    logic        load;
    logic        lzb;
    logic        lamp_test;
    logic [3:0]  a;
    logic        le;
    logic        bi_n;
    logic        lt_n;
    logic [3:0]  dig;
    logic        err;

    modport master (
        output data, load, lzb, lamp_test,
        input  a, le, bi_n, lt_n, dig, err
    );

    modport slave (
        input  data, load, lzb, lamp_test,
        output a, le, bi_n, lt_n, dig, err
    );
endinterface

// File: rtl/hc4511_scan.sv
// Four-digit multiplexed scan driver for an HC4511 decoder with per-slot blanking guard.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_BLANK | cnt < GUARD: decoder transparent, display blanked, A settling
// ST_SHOW  | cnt >= GUARD: decoder latched, digit lit unless zero-blanked
module hc4511_scan #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned GUARD = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    hc4511_scan_if.slave  bus
);
    typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_e;

    localparam logic [15:0] CNT_LAST  = 16'(DIV - 1);
    localparam logic [15:0] CNT_GUARD = 16'(GUARD);

    state_e      state_q, state_d;
    logic [15:0] val_q, val_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  dig_q, dig_d;
    logic        zb_q, zb_d;
    logic        le_q, le_d;
    logic        bi_n_q, bi_n_d;
    logic        lt_n_q, lt_n_d;
    logic        wrap;

    function automatic logic has_non_bcd(input logic [15:0] v);
        return (v[3:0] > 4'd9) | (v[7:4] > 4'd9) | (v[11:8] > 4'd9) | (v[15:12] > 4'd9);
    endfunction

    // Digit i is blanked only when it and every more significant nibble are zero.
    function automatic logic zero_blank(input logic [15:0] v, input logic [1:0] i,
                                        input logic lzb);
        logic z;
        case (i)
            2'd1:    z = (v[15:4] == 12'd0);
            2'd2:    z = (v[15:8] == 8'd0);
            2'd3:    z = (v[15:12] == 4'd0);
            default: z = 1'b0;
        endcase
        return lzb & z;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_BLANK;
            val_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            dig_q   <= 4'b0001;
            zb_q    <= 1'b0;
            le_q    <= 1'b0;
            bi_n_q  <= 1'b0;
            lt_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            dig_q   <= dig_d;
            zb_q    <= zb_d;
            le_q    <= le_d;
            bi_n_q  <= bi_n_d;
            lt_n_q  <= lt_n_d;
        end
    end

    always_comb begin
        val_d   = val_q;
        err_d   = err_q;
        idx_d   = idx_q;
        a_d     = a_q;
        dig_d   = dig_q;
        zb_d    = zb_q;
        state_d = state_q;
        lt_n_d  = ~bus.lamp_test;

        if (bus.load) begin
            val_d = bus.data;
            err_d = has_non_bcd(bus.data);
        end

        wrap  = (cnt_q == CNT_LAST);
        cnt_d = wrap ? '0 : cnt_q + 16'd1;

        // Slot entry samples the pre-load value so a coincident Load shows next slot.
        if (wrap) begin
            idx_d = idx_q + 2'd1;
            a_d   = 4'(val_q >> {idx_d, 2'b00});
            dig_d = 4'b0001 << idx_d;
            zb_d  = zero_blank(val_q, idx_d, bus.lzb);
        end

        case (state_q)
            ST_BLANK: if (cnt_d == CNT_GUARD) state_d = ST_SHOW;
            ST_SHOW:  if (wrap)               state_d = ST_BLANK;
            default:                          state_d = ST_BLANK;
        endcase

        le_d   = (state_d == ST_SHOW);
        bi_n_d = (state_d == ST_SHOW) & ~zb_d;
    end

    assign bus.a    = a_q;
    assign bus.dig  = dig_q;
    assign bus.le   = le_q;
    assign bus.bi_n = bi_n_q;
    assign bus.lt_n = lt_n_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_hc4511_scan.sv
// Directed bench for hc4511_scan: expected slots are queued as values are loaded
// and compared cycle by cycle as each digit slot is scanned out.
module tb_hc4511_scan;
    localparam int DIV   = 8;
    localparam int GUARD = 2;

    typedef struct packed {
        logic [3:0] dig;
        logic [3:0] a;
        logic       blank;
        logic       err;
    } slot_t;

    logic clk_i = 1'b0;
    logic rst_n_i;
    int   checks = 0;
    int   failures = 0;
    slot_t exp_q[$];

    hc4511_scan_if bus ();

    hc4511_scan #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        bus.load = 1'b0;
    endtask

    task automatic push_slot(input logic [3:0] dig, input logic [3:0] a,
                             input logic blank, input logic err);
        slot_t s;
        s.dig = dig; s.a = a; s.blank = blank; s.err = err;
        exp_q.push_back(s);
    endtask

    // Advance to the first sample of the next slot (LE falling back to 0).
    task automatic sync_slot(output bit ok);
        bit seen;
        ok = 1'b0;
        seen = (bus.le === 1'b1);
        for (int n = 0; n < 3 * DIV; n++) begin
            step();
            if (bus.le === 1'b1) seen = 1'b1;
            else if (seen) begin ok = 1'b1; break; end
        end
        chk("sync_slot", {15'd0, ok}, 16'd1);
    endtask

    task automatic sync_digit(input int d);
        bit ok;
        bit hit;
        logic [3:0] want;
        want = 4'b0001 << d;
        hit = 1'b0;
        for (int n = 0; n < 6; n++) begin
            sync_slot(ok);
            if (!ok) break;
            if (bus.dig === want) begin hit = 1'b1; break; end
        end
        chk($sformatf("sync_digit%0d", d), {15'd0, hit}, 16'd1);
    endtask

    // Called on the first sample of a slot; leaves on its last sample.
    task automatic check_slot(input int mid_at, input logic [15:0] mid_data);
        slot_t e;
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk($sformatf("err d%b", e.dig), {15'd0, bus.err}, {15'd0, e.err});
        for (int i = 0; i < DIV; i++) begin
            chk($sformatf("dig d%b c%0d", e.dig, i), {12'd0, bus.dig}, {12'd0, e.dig});
            chk($sformatf("a d%b c%0d", e.dig, i), {12'd0, bus.a}, {12'd0, e.a});
            chk($sformatf("le d%b c%0d", e.dig, i), {15'd0, bus.le},
                {15'd0, (i >= GUARD)});
            chk($sformatf("bi_n d%b c%0d", e.dig, i), {15'd0, bus.bi_n},
                {15'd0, (i >= GUARD) && !e.blank});
            if (i == mid_at) begin
                bus.data = mid_data;
                bus.load = 1'b1;
            end
            if (i < DIV - 1) step();
        end
    endtask

    task automatic run_slots(input int n);
        bit ok;
        for (int k = 0; k < n; k++) begin
            if (k > 0) sync_slot(ok);
            check_slot(-1, 16'h0);
        end
    endtask

    // Load lands on cnt=1 of a slot, so the next slot entry already sees it.
    task automatic load_value(input logic [15:0] d, input logic lzb);
        bit ok;
        sync_slot(ok);
        bus.data = d;
        bus.lzb  = lzb;
        bus.load = 1'b1;
        step();
    endtask

    initial begin
        bit ok;
        rst_n_i       = 1'b0;
        bus.data      = 16'hFFFF;
        bus.load      = 1'b1;
        bus.lzb       = 1'b0;
        bus.lamp_test = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i  = 1'b1;
        bus.load = 1'b0;

        // Reset state, reset beating Load, and the first slot after release
        chk("rst_lt_n", {15'd0, bus.lt_n}, 16'd1);
        chk("rst_err", {15'd0, bus.err}, 16'd0);
        push_slot(4'b0001, 4'h0, 1'b0, 1'b0);
        check_slot(-1, 16'h0);

        // Scan order
        load_value(16'h1234, 1'b0);
        push_slot(4'b0001, 4'h4, 1'b0, 1'b0);
        push_slot(4'b0010, 4'h3, 1'b0, 1'b0);
        push_slot(4'b0100, 4'h2, 1'b0, 1'b0);
        push_slot(4'b1000, 4'h1, 1'b0, 1'b0);
        sync_digit(0);
        run_slots(4);

        // Leading-zero blanking on and off
        load_value(16'h0040, 1'b1);
        push_slot(4'b0001, 4'h0, 1'b0, 1'b0);
        push_slot(4'b0010, 4'h4, 1'b0, 1'b0);
        push_slot(4'b0100, 4'h0, 1'b1, 1'b0);
        push_slot(4'b1000, 4'h0, 1'b1, 1'b0);
        sync_digit(0);
        run_slots(4);
        load_value(16'h0040, 1'b0);
        push_slot(4'b0001, 4'h0, 1'b0, 1'b0);
        push_slot(4'b0010, 4'h4, 1'b0, 1'b0);
        push_slot(4'b0100, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1000, 4'h0, 1'b0, 1'b0);
        sync_digit(0);
        run_slots(4);

        // Mid-slot load, then a load coinciding with the slot wrap
        load_value(16'h1234, 1'b0);
        push_slot(4'b0010, 4'h3, 1'b0, 1'b0);
        push_slot(4'b0100, 4'h9, 1'b0, 1'b0);
        push_slot(4'b1000, 4'h9, 1'b0, 1'b0);
        push_slot(4'b0001, 4'h9, 1'b0, 1'b0);
        push_slot(4'b0010, 4'h9, 1'b0, 1'b0);
        push_slot(4'b0100, 4'h6, 1'b0, 1'b0);
        sync_digit(1);
        check_slot(5, 16'h9999);
        sync_slot(ok); check_slot(-1, 16'h0);
        sync_slot(ok); check_slot(-1, 16'h0);
        sync_slot(ok); check_slot(7, 16'h5678);
        sync_slot(ok); check_slot(-1, 16'h0);
        sync_slot(ok); check_slot(-1, 16'h0);

        // Non-BCD nibble sets Err and is still scanned out
        load_value(16'h12A4, 1'b0);
        chk("err_set", {15'd0, bus.err}, 16'd1);
        push_slot(4'b0001, 4'h4, 1'b0, 1'b1);
        push_slot(4'b0010, 4'hA, 1'b0, 1'b1);
        push_slot(4'b0100, 4'h2, 1'b0, 1'b1);
        push_slot(4'b1000, 4'h1, 1'b0, 1'b1);
        sync_digit(0);
        run_slots(4);
        load_value(16'h0000, 1'b0);
        chk("err_clr", {15'd0, bus.err}, 16'd0);

        // Lamp test keeps the scan running
        bus.lamp_test = 1'b1;
        step();
        chk("lt_n_on", {15'd0, bus.lt_n}, 16'd0);
        push_slot(4'b0001, 4'h0, 1'b0, 1'b0);
        push_slot(4'b0010, 4'h0, 1'b0, 1'b0);
        push_slot(4'b0100, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1000, 4'h0, 1'b0, 1'b0);
        sync_digit(0);
        run_slots(4);
        bus.lamp_test = 1'b0;
        step();
        chk("lt_n_off", {15'd0, bus.lt_n}, 16'd1);

        // Reset in the middle of the digit-2 slot
        load_value(16'h1234, 1'b0);
        sync_digit(2);
        repeat (4) step();
        chk("pre_rst_dig", {12'd0, bus.dig}, 16'h0004);
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        chk("mid_rst_dig", {12'd0, bus.dig}, 16'h0001);
        chk("mid_rst_a", {12'd0, bus.a}, 16'h0000);
        chk("mid_rst_bi_n", {15'd0, bus.bi_n}, 16'd0);
        chk("mid_rst_le", {15'd0, bus.le}, 16'd0);
        push_slot(4'b0001, 4'h0, 1'b0, 1'b0);
        push_slot(4'b0010, 4'h0, 1'b0, 1'b0);
        push_slot(4'b0100, 4'h0, 1'b0, 1'b0);
        push_slot(4'b1000, 4'h0, 1'b0, 1'b0);
        run_slots(4);

        chk("sb_drained", exp_q.size() == 0 ? 16'd1 : 16'd0, 16'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
